multicycle_control: RTL and testbench

- Multicycle RISC-V control FSM that sits directly upstream of the ALU and drives its ALUControl plus all datapath mux, enable and write strobes.
- Sequences each instruction through Fetch/Decode/Execute/Memory/Writeback.
- Consumes the ALU's Zero flag in the branch state.
- Supports lw, sw, R-type (add/sub/and/or/slt), I-type ALU (addi/andi/ori/slti), beq and jal.
- Memory accesses stall on a ready handshake.

---
 rtl/multicycle_control.sv | 171 +++++++++++++++++
 tb/tb_multicycle_control.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle RISC-V control FSM driving ALU control and datapath strobes
module multicycle_control #(
  parameter bit TRAP_ON_ILLEGAL = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       RegWrite,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       IllegalInstr,
  output logic       InstrDone
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_JAL      = 4'd8,
    S_ALUWB    = 4'd9,
    S_BEQ      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  state_t     state_q, state_d;
  logic [1:0] alu_op;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_FETCH;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d      = S_FETCH;
    PCWrite      = 1'b0;
    AdrSrc       = 1'b0;
    MemWrite     = 1'b0;
    IRWrite      = 1'b0;
    ResultSrc    = 2'b00;
    ALUSrcA      = 2'b00;
    ALUSrcB      = 2'b00;
    RegWrite     = 1'b0;
    alu_op       = 2'b00;
    IllegalInstr = 1'b0;
    InstrDone    = 1'b0;
    case (state_q)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = MemReady;
        PCWrite   = MemReady;
        state_d   = MemReady ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default: begin
            IllegalInstr = 1'b1;
            state_d      = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc  = 1'b1;
        state_d = MemReady ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc    = 1'b1;
        MemWrite  = 1'b1;
        InstrDone = MemReady;
        state_d   = MemReady ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b10;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = 2'b10;
        state_d = S_ALUWB;
      end
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA   = 2'b10;
        alu_op    = 2'b01;
        PCWrite   = Zero;
        InstrDone = 1'b1;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  // op[5] separates R-type sub from I-type addi, which has no subtract form
  always_comb begin
    ALUControl = 3'b000;
    case (alu_op)
      2'b01: ALUControl = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

  always_comb begin
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - scoreboard bench for multicycle_control, both TRAP_ON_ILLEGAL settings
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       MemReady;

  logic       pcw0, adr0, mw0, irw0, rw0, ill0, done0;
  logic [1:0] rs0, sa0, sb0, imm0;
  logic [2:0] alu0;
  logic       pcw1, adr1, mw1, irw1, rw1, ill1, done1;
  logic [1:0] rs1, sa1, sb1, imm1;
  logic [2:0] alu1;

  logic [17:0] vec0, vec1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  multicycle_control #(.TRAP_ON_ILLEGAL(1'b0)) dut0 (
    .clk(clk), .reset_n(reset_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .MemReady(MemReady), .PCWrite(pcw0), .AdrSrc(adr0), .MemWrite(mw0),
    .IRWrite(irw0), .ResultSrc(rs0), .ALUSrcA(sa0), .ALUSrcB(sb0), .RegWrite(rw0),
    .ImmSrc(imm0), .ALUControl(alu0), .IllegalInstr(ill0), .InstrDone(done0)
  );

  multicycle_control #(.TRAP_ON_ILLEGAL(1'b1)) dut1 (
    .clk(clk), .reset_n(reset_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .MemReady(MemReady), .PCWrite(pcw1), .AdrSrc(adr1), .MemWrite(mw1),
    .IRWrite(irw1), .ResultSrc(rs1), .ALUSrcA(sa1), .ALUSrcB(sb1), .RegWrite(rw1),
    .ImmSrc(imm1), .ALUControl(alu1), .IllegalInstr(ill1), .InstrDone(done1)
  );

  assign vec0 = {pcw0, adr0, mw0, irw0, rs0, sa0, sb0, rw0, imm0, alu0, ill0, done0};
  assign vec1 = {pcw1, adr1, mw1, irw1, rs1, sa1, sb1, rw1, imm1, alu1, ill1, done1};

  // {PCWrite,AdrSrc,MemWrite,IRWrite,ResultSrc,ALUSrcA,ALUSrcB,RegWrite,ImmSrc,ALUControl,IllegalInstr,InstrDone}
  function automatic logic [17:0] v(input logic pcw, adr, mw, irw, input logic [1:0] rs, sa, sb,
                                    input logic rw, input logic [1:0] imm, input logic [2:0] alu,
                                    input logic ill, done);
    return {pcw, adr, mw, irw, rs, sa, sb, rw, imm, alu, ill, done};
  endfunction

  function automatic logic [17:0] f_fetch(input logic mr, input logic [1:0] imm);
    return v(mr, 0, 0, mr, 2'b10, 2'b00, 2'b10, 0, imm, 3'b000, 0, 0);
  endfunction
  function automatic logic [17:0] f_decode(input logic [1:0] imm, input logic ill);
    return v(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 0, imm, 3'b000, ill, 0);
  endfunction
  function automatic logic [17:0] f_memadr(input logic [1:0] imm);
    return v(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, imm, 3'b000, 0, 0);
  endfunction
  function automatic logic [17:0] f_memread(input logic [1:0] imm);
    return v(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0, imm, 3'b000, 0, 0);
  endfunction
  function automatic logic [17:0] f_memwb(input logic [1:0] imm);
    return v(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 1, imm, 3'b000, 0, 1);
  endfunction
  function automatic logic [17:0] f_memwrite(input logic mr, input logic [1:0] imm);
    return v(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0, imm, 3'b000, 0, mr);
  endfunction
  function automatic logic [17:0] f_exec(input logic [1:0] srcb, imm, input logic [2:0] alu);
    return v(0, 0, 0, 0, 2'b00, 2'b10, srcb, 0, imm, alu, 0, 0);
  endfunction
  function automatic logic [17:0] f_aluwb(input logic [1:0] imm);
    return v(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, imm, 3'b000, 0, 1);
  endfunction
  function automatic logic [17:0] f_jal(input logic [1:0] imm);
    return v(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 0, imm, 3'b000, 0, 0);
  endfunction
  function automatic logic [17:0] f_beq(input logic z, input logic [1:0] imm);
    return v(z, 0, 0, 0, 2'b00, 2'b10, 2'b00, 0, imm, 3'b001, 0, 1);
  endfunction
  function automatic logic [17:0] f_trap(input logic [1:0] imm);
    return v(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, imm, 3'b000, 0, 0);
  endfunction

  typedef struct {
    logic [17:0] e0;
    logic [17:0] e1;
    string       tag;
  } exp_t;
  exp_t scb[$];

  task automatic chk(input string name, input logic [17:0] act, input logic [17:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b required %b", name, act, exp);
    end
  endtask

  // Push the expected outputs for the current cycle and advance one clock
  task automatic cyc(input string tag, input logic [17:0] e0, input logic [17:0] e1);
    exp_t it;
    it.e0 = e0;
    it.e1 = e1;
    it.tag = tag;
    scb.push_back(it);
    @(posedge clk);
    #1;
  endtask

  task automatic both(input string tag, input logic [17:0] e);
    cyc(tag, e, e);
  endtask

  always @(negedge clk) begin
    if (scb.size() != 0) begin
      exp_t it;
      it = scb.pop_front();
      chk({it.tag, "/p0"}, vec0, it.e0);
      chk({it.tag, "/p1"}, vec1, it.e1);
    end
  end

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BEQ = 7'b1100011;
  localparam logic [6:0] JAL = 7'b1101111;

  logic [2:0] f3_tab  [4] = '{3'b010, 3'b110, 3'b111, 3'b001};
  logic [2:0] alu_tab [4] = '{3'b101, 3'b011, 3'b010, 3'b000};

  initial begin
    reset_n = 1'b0; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; Zero = 1'b0; MemReady = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    both("rst_hold", f_fetch(1'b0, 2'b00));

    // sw, interrupted by reset while MemWrite is asserted
    reset_n = 1'b1; op = SW; MemReady = 1'b1;
    both("sw0_fetch", f_fetch(1'b1, 2'b01));
    both("sw0_dec", f_decode(2'b01, 1'b0));
    both("sw0_adr", f_memadr(2'b01));
    MemReady = 1'b0;
    both("sw0_wait", f_memwrite(1'b0, 2'b01));
    chk("sw0_mw_before_rst/p0", {17'd0, mw0}, 18'd1);
    reset_n = 1'b0;
    #1;
    chk("sw0_mw_async_rst/p0", {17'd0, mw0}, 18'd0);
    chk("sw0_mw_async_rst/p1", {17'd0, mw1}, 18'd0);
    MemReady = 1'b1;
    both("rst_gate_fetch", f_fetch(1'b1, 2'b01));
    reset_n = 1'b1;

    // lw, 5 cycles
    op = LW;
    both("lw_fetch", f_fetch(1'b1, 2'b00));
    both("lw_dec", f_decode(2'b00, 1'b0));
    both("lw_adr", f_memadr(2'b00));
    both("lw_rd", f_memread(2'b00));
    both("lw_wb", f_memwb(2'b00));

    // R-type sub
    op = RT; funct3 = 3'b000; funct7b5 = 1'b1;
    both("sub_fetch", f_fetch(1'b1, 2'b00));
    both("sub_dec", f_decode(2'b00, 1'b0));
    both("sub_exec", f_exec(2'b00, 2'b00, 3'b001));
    both("sub_wb", f_aluwb(2'b00));

    // R-type slt / or / and / unsupported funct3
    funct7b5 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      funct3 = f3_tab[i];
      both("rf_fetch", f_fetch(1'b1, 2'b00));
      both("rf_dec", f_decode(2'b00, 1'b0));
      both($sformatf("rf_exec_f3_%b", f3_tab[i]), f_exec(2'b00, 2'b00, alu_tab[i]));
      both("rf_wb", f_aluwb(2'b00));
    end

    // addi with funct7b5 set still adds
    op = IT; funct3 = 3'b000; funct7b5 = 1'b1;
    both("addi_fetch", f_fetch(1'b1, 2'b00));
    both("addi_dec", f_decode(2'b00, 1'b0));
    both("addi_exec", f_exec(2'b01, 2'b00, 3'b000));
    both("addi_wb", f_aluwb(2'b00));

    // beq taken, with one fetch stall
    op = BEQ; Zero = 1'b1; MemReady = 1'b0;
    both("beq1_fstall", f_fetch(1'b0, 2'b10));
    MemReady = 1'b1;
    both("beq1_fetch", f_fetch(1'b1, 2'b10));
    both("beq1_dec", f_decode(2'b10, 1'b0));
    both("beq1_br", f_beq(1'b1, 2'b10));

    // beq not taken
    Zero = 1'b0;
    both("beq0_fetch", f_fetch(1'b1, 2'b10));
    both("beq0_dec", f_decode(2'b10, 1'b0));
    both("beq0_br", f_beq(1'b0, 2'b10));

    // jal
    op = JAL;
    both("jal_fetch", f_fetch(1'b1, 2'b11));
    both("jal_dec", f_decode(2'b11, 1'b0));
    both("jal_jal", f_jal(2'b11));
    both("jal_wb", f_aluwb(2'b11));

    // sw with three not-ready cycles
    op = SW;
    both("sw_fetch", f_fetch(1'b1, 2'b01));
    both("sw_dec", f_decode(2'b01, 1'b0));
    both("sw_adr", f_memadr(2'b01));
    MemReady = 1'b0;
    for (int i = 0; i < 3; i++) both("sw_wait", f_memwrite(1'b0, 2'b01));
    MemReady = 1'b1;
    both("sw_ready", f_memwrite(1'b1, 2'b01));

    // illegal opcode: param 0 returns to FETCH, param 1 parks in TRAP
    op = 7'b0000000;
    both("ill_fetch", f_fetch(1'b1, 2'b00));
    both("ill_dec", f_decode(2'b00, 1'b1));
    cyc("ill_after1", f_fetch(1'b1, 2'b00), f_trap(2'b00));
    cyc("ill_after2", f_decode(2'b00, 1'b1), f_trap(2'b00));
    cyc("ill_after3", f_fetch(1'b1, 2'b00), f_trap(2'b00));

    n_cmp++;
    if (scb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d left required 0", scb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish required finish");
    $fatal(1, "timeout");
  end

endmodule
